// File: rtl/nes_bus_pkg.sv
// NES CPU bus constants and sprite DMA state encoding.
// Shared by the DMA controller and the integration top.
package nes_bus_pkg;

    localparam logic [15:0] ADDR_SPR_RAM_DMA  = 16'h4014;
    localparam logic [15:0] ADDR_SPR_RAM_DATA = 16'h2004;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

endpackage

// File: rtl/spr_dma_ctrl.sv
// Sprite-RAM DMA engine: snoops 4014h writes, halts the CPU and copies
// one source page to the SPR-RAM data port, one read plus one write per byte.
module spr_dma_ctrl
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = ADDR_SPR_RAM_DMA,
    parameter logic [15:0] DEST_ADDR = ADDR_SPR_RAM_DATA,
    parameter int          XFER_LEN  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_wen,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_data_out,
    output logic        dma_ren,
    output logic        dma_wen,
    input  logic [7:0]  dma_data_in
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state;
    logic       cyc_par;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_q;

    logic trig;
    assign trig = cpu_wen && (cpu_addr_out == TRIG_ADDR);

    // Outputs are loaded together with the state they belong to,
    // so every output is a flop and never sees the cpu_* inputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cyc_par      <= 1'b0;
            page         <= 8'h00;
            idx          <= 8'h00;
            data_q       <= 8'h00;
            cpu_rdy      <= 1'b1;
            dma_active   <= 1'b0;
            dma_addr     <= 16'h0000;
            dma_data_out <= 8'h00;
            dma_ren      <= 1'b0;
            dma_wen      <= 1'b0;
        end else begin
            cyc_par <= ~cyc_par;
            dma_ren <= 1'b0;
            dma_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        page       <= cpu_data_out;
                        idx        <= 8'h00;
                        state      <= HALT;
                        cpu_rdy    <= 1'b0;
                        dma_active <= 1'b1;
                    end
                end
                HALT: begin
                    // First read must land on an even cycle.
                    if (cyc_par) begin
                        state    <= READ;
                        dma_addr <= {page, idx};
                        dma_ren  <= 1'b1;
                    end else begin
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    state    <= READ;
                    dma_addr <= {page, idx};
                    dma_ren  <= 1'b1;
                end
                READ: begin
                    data_q       <= dma_data_in;
                    state        <= WRITE;
                    dma_addr     <= DEST_ADDR;
                    dma_data_out <= dma_data_in;
                    dma_wen      <= 1'b1;
                end
                WRITE: begin
                    dma_data_out <= 8'h00;
                    if (idx == LAST_IDX) begin
                        state      <= IDLE;
                        cpu_rdy    <= 1'b1;
                        dma_active <= 1'b0;
                        dma_addr   <= 16'h0000;
                    end else begin
                        idx      <= idx + 8'd1;
                        state    <= READ;
                        dma_addr <= {page, idx + 8'd1};
                        dma_ren  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spr_dma_ctrl.sv
// Self-checking bench for spr_dma_ctrl: RAM responder model, bus monitor
// and per-scenario tasks compared against a page-copy reference.
module tb_spr_dma_ctrl;

    localparam int XFER = 256;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        cpu_wen;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data_out;
    logic        dma_ren;
    logic        dma_wen;
    logic [7:0]  dma_data_in;

    logic [7:0] mem [0:65535];

    int checks;
    int errors;

    logic [15:0] rd_q [$];
    logic [15:0] wa_q [$];
    logic [7:0]  wd_q [$];
    int          halt_cnt;
    logic        halt_par;
    logic        first_ren_par;
    logic        prev_rdy;
    logic        tbpar;

    spr_dma_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr_out (cpu_addr_out),
        .cpu_data_out (cpu_data_out),
        .cpu_wen      (cpu_wen),
        .cpu_rdy      (cpu_rdy),
        .dma_active   (dma_active),
        .dma_addr     (dma_addr),
        .dma_data_out (dma_data_out),
        .dma_ren      (dma_ren),
        .dma_wen      (dma_wen),
        .dma_data_in  (dma_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dma_data_in = dma_ren ? mem[dma_addr] : 8'h00;

    // Cycle parity: 0 in the first cycle after reset, toggles every clock.
    always @(posedge clk) tbpar <= rst ? 1'b0 : ~tbpar;

    always @(negedge clk) begin
        if (dma_ren) begin
            if (rd_q.size() == 0) first_ren_par = tbpar;
            rd_q.push_back(dma_addr);
        end
        if (dma_wen) begin
            wa_q.push_back(dma_addr);
            wd_q.push_back(dma_data_out);
        end
        if (cpu_rdy === 1'b0) begin
            if (prev_rdy === 1'b1) halt_par = tbpar;
            halt_cnt++;
        end
        prev_rdy = cpu_rdy;
    end

    function automatic int copy_errs(input logic [7:0] pg);
        int n;
        logic [15:0] a;
        n = 0;
        if (rd_q.size() != XFER) n++;
        if (wd_q.size() != XFER) n++;
        for (int i = 0; i < XFER; i++) begin
            a = {pg, 8'(i)};
            if (i < rd_q.size() && rd_q[i] !== a) n++;
            if (i < wa_q.size() && wa_q[i] !== 16'h2004) n++;
            if (i < wd_q.size() && wd_q[i] !== mem[a]) n++;
        end
        return n;
    endfunction

    task automatic clear_mon();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        halt_cnt = 0;
    endtask

    task automatic fill_rand(input logic [7:0] pg);
        for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr_out = a;
        cpu_data_out = d;
        cpu_wen = 1'b1;
        @(posedge clk);
        #1;
        cpu_wen = 1'b0;
        cpu_addr_out = 16'h0000;
        cpu_data_out = 8'h00;
    endtask

    task automatic wait_idle();
        int n;
        for (n = 0; n < 3000 && cpu_rdy !== 1'b1; n++) @(negedge clk);
        checks++;
        if (cpu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle: cpu_rdy=%b after %0d cycles, need 1", cpu_rdy, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_copy(input logic [7:0] pg);
        clear_mon();
        cpu_wr(16'h4014, pg);
        wait_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_wen = 1'b0;
        cpu_addr_out = 16'h0000;
        cpu_data_out = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({cpu_rdy, dma_active, dma_ren, dma_wen} !== 4'b1000
            || dma_addr !== 16'h0000 || dma_data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset: rdy/act/ren/wen=%b%b%b%b addr=%h data=%h, need 1000 0000 00",
                     cpu_rdy, dma_active, dma_ren, dma_wen, dma_addr, dma_data_out);
        end
    endtask

    task automatic test_basic_copy();
        int exp_halt;
        for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
        do_copy(8'h02);
        checks++;
        if (copy_errs(8'h02) !== 0) begin
            errors++;
            $display("FAIL basic_copy: %0d bad entries, need 0", copy_errs(8'h02));
        end
        checks++;
        if (wd_q.size() < 2 || wd_q[0] !== 8'hA5 || wd_q[1] !== 8'hA4) begin
            errors++;
            $display("FAIL basic_first_bytes: got %0d writes, need A5,A4 first", wd_q.size());
        end
        exp_halt = (halt_par == 1'b0) ? 514 : 513;
        checks++;
        if (halt_cnt !== exp_halt) begin
            errors++;
            $display("FAIL basic_halt_len: %0d, need %0d", halt_cnt, exp_halt);
        end
    endtask

    task automatic test_parity();
        logic [7:0] pg;
        for (int want = 0; want < 2; want++) begin
            pg = 8'h10 + 8'(want);
            fill_rand(pg);
            // HALT parity is the inverse of the trigger cycle's parity.
            if (tbpar === 1'(want)) begin
                @(posedge clk);
                #1;
            end
            do_copy(pg);
            checks++;
            if (halt_par !== 1'(want)) begin
                errors++;
                $display("FAIL parity_setup: halt par %b, need %0d", halt_par, want);
            end
            checks++;
            if (halt_cnt !== ((want == 0) ? 514 : 513)) begin
                errors++;
                $display("FAIL parity_halt_len: %0d, need %0d", halt_cnt,
                         (want == 0) ? 514 : 513);
            end
            checks++;
            if (first_ren_par !== 1'b0) begin
                errors++;
                $display("FAIL parity_first_ren: par %b, need 0", first_ren_par);
            end
            checks++;
            if (copy_errs(pg) !== 0) begin
                errors++;
                $display("FAIL parity_copy: %0d bad entries, need 0", copy_errs(pg));
            end
        end
    endtask

    task automatic test_retrigger();
        for (int i = 0; i < 256; i++) mem[16'h0200 + 16'(i)] = 8'($urandom);
        fill_rand(8'h07);
        clear_mon();
        cpu_wr(16'h4014, 8'h02);
        repeat (50) @(posedge clk);
        #1;
        cpu_addr_out = 16'h4014;
        cpu_data_out = 8'h07;
        cpu_wen = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cpu_wen = 1'b0;
        cpu_addr_out = 16'h0000;
        cpu_data_out = 8'h00;
        wait_idle();
        checks++;
        if (copy_errs(8'h02) !== 0) begin
            errors++;
            $display("FAIL retrigger_copy: %0d bad entries, need 0", copy_errs(8'h02));
        end
        checks++;
        if (wd_q.size() !== XFER) begin
            errors++;
            $display("FAIL retrigger_count: %0d writes, need %0d", wd_q.size(), XFER);
        end
    endtask

    task automatic test_page_boundary();
        int zero_rd;
        fill_rand(8'hFF);
        do_copy(8'hFF);
        zero_rd = 0;
        foreach (rd_q[i]) if (rd_q[i] === 16'h0000) zero_rd++;
        checks++;
        if (rd_q.size() == 0 || rd_q[rd_q.size() - 1] !== 16'hFFFF) begin
            errors++;
            $display("FAIL boundary_last_read: got %0d reads, need last at FFFF", rd_q.size());
        end
        checks++;
        if (zero_rd !== 0) begin
            errors++;
            $display("FAIL boundary_wrap: %0d reads at 0000, need 0", zero_rd);
        end
        checks++;
        if (copy_errs(8'hFF) !== 0) begin
            errors++;
            $display("FAIL boundary_copy: %0d bad entries, need 0", copy_errs(8'hFF));
        end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [7:0] pg;
        fill_rand(8'h33);
        clear_mon();
        cpu_wr(16'h4014, 8'h33);
        for (n = 0; n < 1000 && wd_q.size() < 100; n++) @(negedge clk);
        checks++;
        if (wd_q.size() < 100) begin
            errors++;
            $display("FAIL midreset_progress: %0d writes, need 100", wd_q.size());
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({cpu_rdy, dma_active, dma_ren, dma_wen} !== 4'b1000) begin
            errors++;
            $display("FAIL midreset_outputs: rdy/act/ren/wen=%b%b%b%b, need 1000",
                     cpu_rdy, dma_active, dma_ren, dma_wen);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stays_idle: rdy=%b act=%b, need 1 0", cpu_rdy, dma_active);
        end
        pg = 8'($urandom_range(0, 255));
        fill_rand(pg);
        do_copy(pg);
        checks++;
        if (copy_errs(pg) !== 0) begin
            errors++;
            $display("FAIL midreset_recopy: %0d bad entries, need 0", copy_errs(pg));
        end
    endtask

    task automatic test_non_trigger();
        logic [15:0] addrs [3];
        int bad;
        addrs[0] = 16'h4015;
        addrs[1] = 16'h2004;
        addrs[2] = 16'h4016;
        for (int k = 0; k < 3; k++) begin
            clear_mon();
            cpu_wr(addrs[k], 8'($urandom));
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                if (cpu_rdy !== 1'b1 || dma_active !== 1'b0) bad++;
                @(posedge clk);
                #1;
            end
            checks++;
            if (bad !== 0 || rd_q.size() !== 0) begin
                errors++;
                $display("FAIL non_trigger_%h: %0d busy cycles %0d reads, need 0 0",
                         addrs[k], bad, rd_q.size());
            end
        end
        // A trigger presented while rst is high must be discarded.
        rst = 1'b1;
        cpu_addr_out = 16'h4014;
        cpu_data_out = 8'h02;
        cpu_wen = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_wen = 1'b0;
        cpu_addr_out = 16'h0000;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (cpu_rdy !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL trigger_in_reset: %0d halted cycles, need 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pg;
        for (int k = 0; k < 3; k++) begin
            pg = 8'($urandom_range(0, 255));
            fill_rand(pg);
            do_copy(pg);
            checks++;
            if (copy_errs(pg) !== 0) begin
                errors++;
                $display("FAIL back_to_back_%0d: page %h %0d bad entries, need 0",
                         k, pg, copy_errs(pg));
            end
            checks++;
            if (halt_cnt !== ((halt_par == 1'b0) ? 514 : 513)) begin
                errors++;
                $display("FAIL back_to_back_halt_%0d: %0d cycles, need %0d",
                         k, halt_cnt, (halt_par == 1'b0) ? 514 : 513);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        halt_cnt = 0;
        prev_rdy = 1'b1;
        halt_par = 1'b0;
        first_ren_par = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_basic_copy();
        test_parity();
        test_retrigger();
        test_page_boundary();
        test_mid_reset();
        test_non_trigger();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
